// File: rtl/aes128_decrypt_core.sv
// aes128_decrypt_core: iterative AES-128 block decryptor.
// Expands the key schedule one round key per clock, then applies one
// inverse round per clock. S-boxes are computed arithmetically in GF(2^8).
// Optional build macro: AES_DEC_KEY_CACHE_EN keeps the expanded schedule
// after a run so a repeat start with the same key skips key expansion.
module aes128_decrypt_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    INIT   = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } fsm_t;

  // Multiples of one byte needed by a single InvMixColumns column.
  typedef struct packed {
    logic [7:0] m09;
    logic [7:0] m0b;
    logic [7:0] m0d;
    logic [7:0] m0e;
  } inv_mults_t;

  // ---------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial 0x11b
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; the chain builds a^3, a^7 .. a^127,
  // then squares once. Zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);
    end
    return gf_mul(r, r);
  endfunction

  // Forward S-box: inverse followed by the affine map (used by the key schedule).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map followed by the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the AES-128 key schedule: four words out of four words in.
  function automatic logic [127:0] expand_key(input logic [127:0] prev,
                                              input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = prev[127:96];
    w1  = prev[95:64];
    w2  = prev[63:32];
    w3  = prev[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rc, 24'h000000};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte n sits at bits [127-8n -: 8]; row = n%4, column = n/4.
  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127 - 8*n -: 8] = inv_sbox(s[127 - 8*n -: 8]);
    end
    return o;
  endfunction

  // xtime chain: x2, x4, x8 combine into 09, 0b, 0d, 0e.
  function automatic inv_mults_t inv_mults(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    inv_mults_t m;
    x2    = xtime(a);
    x4    = xtime(x2);
    x8    = xtime(x4);
    m.m09 = x8 ^ a;
    m.m0b = x8 ^ x2 ^ a;
    m.m0d = x8 ^ x4 ^ a;
    m.m0e = x8 ^ x4 ^ x2;
    return m;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    inv_mults_t m0, m1, m2, m3;
    m0 = inv_mults(c[31:24]);
    m1 = inv_mults(c[23:16]);
    m2 = inv_mults(c[15:8]);
    m3 = inv_mults(c[7:0]);
    return {m0.m0e ^ m1.m0b ^ m2.m0d ^ m3.m09,
            m0.m09 ^ m1.m0e ^ m2.m0b ^ m3.m0d,
            m0.m0d ^ m1.m09 ^ m2.m0e ^ m3.m0b,
            m0.m0b ^ m1.m0d ^ m2.m09 ^ m3.m0e};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  fsm_t         fsm_q, fsm_d;
  logic [127:0] rk [0:10];   // round keys; rk[0] is the cipher key
  logic [127:0] blk_q;       // working state
  logic [3:0]   cnt_q;       // key index in KEYEXP, round number in ROUND
  logic [127:0] rk_next;
  logic [127:0] round_out;
  logic         key_hit;

`ifdef AES_DEC_KEY_CACHE_EN
  logic key_valid_q;
  assign key_hit = key_valid_q && (key == rk[0]);
`else
  assign key_hit = 1'b0;
`endif

  // Next round key from the previous one while expanding.
  assign rk_next = expand_key(rk[cnt_q - 4'd1], rcon(cnt_q));

  // One inverse round; the last round (r == 0) skips InvMixColumns.
  always_comb begin
    logic [127:0] ark;
    ark       = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk[cnt_q];
    round_out = (cnt_q == 4'd0) ? ark : inv_mix_columns(ark);
  end

  // State register for the control FSM.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  // Next-state logic for the control FSM.
  always_comb begin
    // NOTE: default first so every path assigns fsm_d and no latch is inferred.
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start) fsm_d = key_hit ? INIT : KEYEXP;
      KEYEXP:  if (cnt_q == 4'd10) fsm_d = INIT;
      INIT:    fsm_d = ROUND;
      ROUND:   if (cnt_q == 4'd0) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Datapath: key schedule, round state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q     <= '0;
      plaintext <= '0;
      done      <= 1'b0;
      cnt_q     <= 4'd0;
      // NOTE: the round-key store is explicitly cleared on reset so the
      // key-match compare never sees stale contents from before reset.
      for (int i = 0; i < 11; i++) rk[i] <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      key_valid_q <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            blk_q <= ciphertext;
            done  <= 1'b0;
            if (!key_hit) begin
              rk[0] <= key;
              cnt_q <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
              key_valid_q <= 1'b0;
`endif
            end
          end
        end
        KEYEXP: begin
          rk[cnt_q] <= rk_next;
          if (cnt_q == 4'd10) begin
            cnt_q <= 4'd9;
`ifdef AES_DEC_KEY_CACHE_EN
            key_valid_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        INIT: begin
          blk_q <= blk_q ^ rk[10];
          cnt_q <= 4'd9;
        end
        ROUND: begin
          blk_q <= round_out;
          if (cnt_q == 4'd0) begin
            plaintext <= round_out;
            done      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// tb_aes128_decrypt_core: vector table plus multi-cycle sequences for the
// iterative AES-128 decryptor, checked against a table-based AES model.
module tb_aes128_decrypt_core;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam int CACHED_LAT = 11;
`else
  localparam int CACHED_LAT = 21;
`endif
  localparam int FULL_LAT = 21;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] H_KEY  = 128'hdf69a7e105d8963b1685ffccee3369fa;
  localparam logic [127:0] H_CT   = 128'h029795d9d0d6129e96f5c12ffe23e5d0;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic [127:0] plaintext;
  logic         done;

  aes128_decrypt_core dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .ciphertext (ciphertext),
    .plaintext  (plaintext),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  typedef struct {
    logic [127:0] pt;
    int           start_cyc;
    int           lat;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: log/antilog tables, generic field multiply
  // ---------------------------------------------------------------------
  logic [7:0] alog_t [256];
  logic [7:0] log_t  [256];
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t[256];

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return alog_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] p, inv, s, cst;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog_t[i] = p;
      log_t[p]  = i[7:0];
      p = p ^ m_xt(p);
    end
    alog_t[255] = 8'h01;
    cst = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : alog_t[(255 - int'(log_t[a])) % 255];
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
               ^ inv[(i+7)%8] ^ cst[i];
      end
      sbox_t[a]  = s;
      isbox_t[s] = a[7:0];
    end
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
             ^ {rc, 24'h000000};
        rc = m_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 16; n++) st[n] = ct[127 - 8*n -: 8] ^ w[40 + n/4][31 - 8*(n%4) -: 8];
    for (int r = 9; r >= 0; r--) begin
      // Undo ShiftRows: the byte that ShiftRows moved to (row, c) goes back.
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          tmp[row + 4*((c + row) % 4)] = st[row + 4*c];
      for (int n = 0; n < 16; n++)
        st[n] = isbox_t[tmp[n]] ^ w[4*r + n/4][31 - 8*(n%4) -: 8];
      if (r != 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = m_mul(a0,8'h0e) ^ m_mul(a1,8'h0b) ^ m_mul(a2,8'h0d) ^ m_mul(a3,8'h09);
          st[4*c+1] = m_mul(a0,8'h09) ^ m_mul(a1,8'h0e) ^ m_mul(a2,8'h0b) ^ m_mul(a3,8'h0d);
          st[4*c+2] = m_mul(a0,8'h0d) ^ m_mul(a1,8'h09) ^ m_mul(a2,8'h0e) ^ m_mul(a3,8'h0b);
          st[4*c+3] = m_mul(a0,8'h0b) ^ m_mul(a1,8'h0d) ^ m_mul(a2,8'h09) ^ m_mul(a3,8'h0e);
        end
      end
    end
    for (int n = 0; n < 16; n++) o[127 - 8*n -: 8] = st[n];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------------------------------------------------------------
  // Monitor: every rising edge of done pops one expected result
  // ---------------------------------------------------------------------
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
        end else begin
          e = sb.pop_front();
          check("plaintext", plaintext, e.pt);
          check("latency", 128'(cyc - e.start_cyc), 128'(e.lat));
        end
      end
      done_prev = done;
    end
  end

  // Wait for all outstanding results, then let DONE return to IDLE.
  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d results pending after %0d cycles expected 0", sb.size(), budget);
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < budget);
    if (done !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got done=%b after %0d cycles expected 1", done, budget);
    end
  endtask

  // Single start pulse; inputs are scrambled while busy.
  task automatic run_vec(input logic [127:0] k, input logic [127:0] ct,
                         input logic [127:0] pt, input int lat);
    exp_t e;
    @(negedge clk);
    key        = k;
    ciphertext = ct;
    start      = 1'b1;
    @(posedge clk);
    #1;
    e.pt = pt; e.start_cyc = cyc; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    key        = rand128();
    ciphertext = rand128();
    wait_empty(40);
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    exp_t e;
    reset      = 1'b1;
    start      = 1'b1;
    key        = C1_KEY;
    ciphertext = C1_CT;
    build_tables();

    vecs[0] = '{C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{B_KEY,  B_CT,  B_PT};
    vecs[2] = '{H_KEY,  H_CT,  model_decrypt(H_KEY, H_CT)};
    for (int i = 3; i < 6; i++) begin
      vecs[i].key = rand128();
      vecs[i].ct  = rand128();
      vecs[i].pt  = model_decrypt(vecs[i].key, vecs[i].ct);
    end

    // Reset held two cycles with start high: outputs cleared, start ignored.
    repeat (2) @(posedge clk);
    #1;
    check("reset_plaintext", plaintext, 128'd0);
    check("reset_done", 128'(done), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("idle_done", 128'(done), 128'd0);
    check("idle_plaintext", plaintext, 128'd0);

    // Table of vectors, each with a distinct key: full expansion every time.
    for (int i = 0; i < 6; i++) run_vec(vecs[i].key, vecs[i].ct, vecs[i].pt, FULL_LAT);

    // Same key twice, then a different key.
    run_vec(C1_KEY, C1_CT, C1_PT, FULL_LAT);
    run_vec(C1_KEY, C1_CT, C1_PT, CACHED_LAT);
    run_vec(B_KEY,  B_CT,  B_PT,  FULL_LAT);

    // Start held high across three back-to-back runs; inputs switch mid-run.
    @(negedge clk);
    key        = H_KEY;
    ciphertext = H_CT;
    start      = 1'b1;
    @(posedge clk);
    #1;
    e.pt = model_decrypt(H_KEY, H_CT); e.start_cyc = cyc; e.lat = FULL_LAT;
    sb.push_back(e);
    repeat (5) @(negedge clk);
    key        = C1_KEY;
    ciphertext = C1_CT;
    wait_done(40);
    @(posedge clk);
    @(posedge clk);
    #1;
    e.pt = C1_PT; e.start_cyc = cyc; e.lat = FULL_LAT;
    sb.push_back(e);
    wait_done(40);
    @(posedge clk);
    @(posedge clk);
    #1;
    e.pt = C1_PT; e.start_cyc = cyc; e.lat = CACHED_LAT;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_empty(40);

    // Reset sampled on the eighth edge after the start edge aborts the run.
    @(negedge clk);
    key        = C1_KEY;
    ciphertext = C1_CT;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_done", 128'(done), 128'd0);
    check("abort_plaintext", plaintext, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("after_abort_done", 128'(done), 128'd0);
    check("after_abort_plaintext", plaintext, 128'd0);
    run_vec(C1_KEY, C1_CT, C1_PT, FULL_LAT);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
